// File: rtl/regfile_mp_pkg.sv
// Shared defaults and types for the multi-port register file.
// Optional bypass: define REGFILE_MP_BYPASS_EN.
package regfile_mp_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int DEPTH_DEF     = 32;
  localparam int NUM_READ_DEF  = 2;
  localparam int NUM_WRITE_DEF = 2;
  localparam int ADDR_W_DEF    = $clog2(DEPTH_DEF);

  typedef logic [DATA_W_DEF-1:0] data_t;
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Busy-bit tracking: reservations set a bit, writes clear it.
// A same-cycle reservation beats a write to the same register.
module regfile_mp_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int NUM_WRITE = NUM_WRITE_DEF,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0] write_addr,
  input  logic [NUM_WRITE-1:0]             write_enable,
  input  logic                             reserve_enable,
  input  logic [ADDR_W-1:0]                reserve_addr,
  output logic [DEPTH-1:0]                 busy
);

  logic [DEPTH-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    for (int w = 0; w < NUM_WRITE; w++) begin
      if (write_enable[w]) busy_nxt[write_addr[w]] = 1'b0;
    end
    if (reserve_enable) busy_nxt[reserve_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with per-register busy reservations.
// Define REGFILE_MP_BYPASS_EN for same-cycle write-to-read bypass.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int NUM_READ  = NUM_READ_DEF,
  parameter int NUM_WRITE = NUM_WRITE_DEF,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_READ-1:0][ADDR_W-1:0]  read_addr,
  output logic [NUM_READ-1:0][DATA_W-1:0]  read_data,
  output logic [NUM_READ-1:0]              read_busy,
  input  logic [NUM_WRITE-1:0][ADDR_W-1:0] write_addr,
  input  logic [NUM_WRITE-1:0][DATA_W-1:0] write_data,
  input  logic [NUM_WRITE-1:0]             write_enable,
  input  logic                             reserve_enable,
  input  logic [ADDR_W-1:0]                reserve_addr
);

  logic [DEPTH-1:0][DATA_W-1:0] regs;
  logic [DEPTH-1:0]             busy;

  regfile_mp_scoreboard #(
    .DEPTH     (DEPTH),
    .NUM_WRITE (NUM_WRITE),
    .ADDR_W    (ADDR_W)
  ) u_sb (
    .clk            (clk),
    .rst            (rst),
    .write_addr     (write_addr),
    .write_enable   (write_enable),
    .reserve_enable (reserve_enable),
    .reserve_addr   (reserve_addr),
    .busy           (busy)
  );

  // Later ports overwrite earlier ones, so the highest index wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (write_enable[w] && write_addr[w] != '0)
          regs[write_addr[w]] <= write_data[w];
      end
    end
  end

  always_comb begin
    read_data = '0;
    read_busy = '0;
    for (int r = 0; r < NUM_READ; r++) begin
      read_data[r] = regs[read_addr[r]];
      read_busy[r] = busy[read_addr[r]];
`ifdef REGFILE_MP_BYPASS_EN
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (write_enable[w] && write_addr[w] == read_addr[r]) begin
          read_data[r] = write_data[w];
          read_busy[r] = reserve_enable &&
                         reserve_addr == read_addr[r];
        end
      end
`endif
      if (rst || read_addr[r] == '0) begin
        read_data[r] = '0;
        read_busy[r] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with a queue of expected reads.
// Build with or without +define+REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0][4:0]      read_addr;
  logic [1:0][31:0]     read_data;
  logic [1:0]           read_busy;
  logic [1:0][4:0]      write_addr;
  logic [1:0][31:0]     write_data;
  logic [1:0]           write_enable;
  logic                 reserve_enable;
  logic [4:0]           reserve_addr;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string tag;
    int    port;
    addr_t addr;
    data_t data;
    logic  busy;
  } exp_t;

  exp_t q[$];

  regfile_mp dut (
    .clk            (clk),
    .rst            (rst),
    .read_addr      (read_addr),
    .read_data      (read_data),
    .read_busy      (read_busy),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .write_enable   (write_enable),
    .reserve_enable (reserve_enable),
    .reserve_addr   (reserve_addr)
  );

  always #5 clk = ~clk;

  task automatic exp_rd(input string tag, input int port,
                        input addr_t a, input data_t d,
                        input logic b);
    exp_t e;
    read_addr[port] = a;
    e.tag = tag; e.port = port; e.addr = a;
    e.data = d; e.busy = b;
    q.push_back(e);
  endtask

  task automatic check_all();
    exp_t e;
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      total++;
      assert (read_data[e.port] === e.data) passed++;
      else $error("FAIL %s data p%0d a%0d: observed %h expected %h",
                  e.tag, e.port, e.addr, read_data[e.port], e.data);
      total++;
      assert (read_busy[e.port] === e.busy) passed++;
      else $error("FAIL %s busy p%0d a%0d: observed %b expected %b",
                  e.tag, e.port, e.addr, read_busy[e.port], e.busy);
    end
  endtask

  task automatic wr(input int p, input addr_t a, input data_t d);
    write_enable[p] = 1'b1;
    write_addr[p]   = a;
    write_data[p]   = d;
  endtask

  task automatic rsv(input addr_t a);
    reserve_enable = 1'b1;
    reserve_addr   = a;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    write_enable   = '0;
    reserve_enable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    read_addr = '0;
    write_addr = '0;
    write_data = '0;
    write_enable = '0;
    reserve_enable = 1'b0;
    reserve_addr = '0;

    // Writes and reservations during reset are ignored.
    #2;
    wr(0, 5'd5, 32'hCAFE0001);
    rsv(5'd6);
    exp_rd("in_reset", 0, 5'd5, 32'h0, 1'b0);
    check_all();
    tick();
    exp_rd("rst_wr", 0, 5'd5, 32'h0, 1'b0);
    exp_rd("rst_rsv", 1, 5'd6, 32'h0, 1'b0);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      exp_rd("sweep", 0, addr_t'(i), 32'h0, 1'b0);
      exp_rd("sweep", 1, addr_t'(31 - i), 32'h0, 1'b0);
      check_all();
    end

    wr(0, 5'd5, 32'hDEADBEEF);
    tick();
    exp_rd("wr5", 1, 5'd5, 32'hDEADBEEF, 1'b0);
    check_all();
    wr(0, 5'd0, 32'h12345678);
    tick();
    exp_rd("wr0", 0, 5'd0, 32'h0, 1'b0);
    check_all();

    wr(0, 5'd7, 32'h11);
    wr(1, 5'd7, 32'h22);
    tick();
    exp_rd("prio", 0, 5'd7, 32'h22, 1'b0);
    exp_rd("prio", 1, 5'd7, 32'h22, 1'b0);
    check_all();

    rsv(5'd9);
    tick();
    exp_rd("rsv9", 0, 5'd9, 32'h0, 1'b1);
    exp_rd("rsv9", 1, 5'd9, 32'h0, 1'b1);
    check_all();
    wr(1, 5'd9, 32'h55);
    tick();
    exp_rd("clr9", 0, 5'd9, 32'h55, 1'b0);
    check_all();
    rsv(5'd9);
    wr(0, 5'd9, 32'h66);
    tick();
    exp_rd("rsvwr9", 1, 5'd9, 32'h66, 1'b1);
    check_all();
    rsv(5'd0);
    tick();
    exp_rd("rsv0", 0, 5'd0, 32'h0, 1'b0);
    check_all();

    // Same-cycle read of a register being written.
    wr(0, 5'd3, 32'h5A);
    tick();
    wr(0, 5'd3, 32'hA5);
`ifdef REGFILE_MP_BYPASS_EN
    exp_rd("byp3", 0, 5'd3, 32'hA5, 1'b0);
`else
    exp_rd("byp3", 0, 5'd3, 32'h5A, 1'b0);
`endif
    check_all();
    tick();
    exp_rd("post3", 0, 5'd3, 32'hA5, 1'b0);
    check_all();

    wr(1, 5'd9, 32'h77);
`ifdef REGFILE_MP_BYPASS_EN
    exp_rd("byp9", 1, 5'd9, 32'h77, 1'b0);
`else
    exp_rd("byp9", 1, 5'd9, 32'h66, 1'b1);
`endif
    check_all();
    tick();
    exp_rd("post9", 1, 5'd9, 32'h77, 1'b0);
    check_all();

    // Busy persists with no write.
    rsv(5'd12);
    tick();
    repeat (20) @(posedge clk);
    #1;
    exp_rd("hold12", 0, 5'd12, 32'h0, 1'b1);
    check_all();

    wr(0, 5'd4, 32'h99);
    tick();
    exp_rd("wr4", 0, 5'd4, 32'h99, 1'b0);
    exp_rd("wr4b", 1, 5'd12, 32'h0, 1'b1);
    check_all();
    #1;
    rst = 1'b1;
    exp_rd("arst4", 0, 5'd4, 32'h0, 1'b0);
    exp_rd("arst12", 1, 5'd12, 32'h0, 1'b0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    wr(0, 5'd4, 32'h33);
    tick();
    exp_rd("first_wr", 0, 5'd4, 32'h33, 1'b0);
    exp_rd("cleared", 1, 5'd12, 32'h0, 1'b0);
    check_all();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
